// File: rtl/svfloat_unpacker.sv
// svfloat package: packed IEEE-754 single-precision container shared by the
// unpacker and anything that feeds it. Field names are what the unpacker
// reads, so other float types only need sign/exponent/mantissa members.
package svfloat;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float32;
endpackage

// Purpose: unpack a packed float into sign / unbiased exponent / explicit
//          mantissa with special-value flags; denormals are normalised.
// Latency: 1 cycle from acceptance; denormals add one cycle per leading zero.
// Backpressure: result held while out_valid && !out_ready; input stalled then.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     input handshake, in_data is the packed float
//   out_valid/out_ready   output handshake
//   is_inf/is_nan/is_zero special-value classification
//   d_sign, d_exp, d_man  value = (-1)^d_sign * d_man * 2^(d_exp - man_width)
module svfloat_unpacker #(
  parameter type float  = svfloat::float32,
  parameter int  ewidth = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  float                                 in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 is_inf,
  output logic                                 is_nan,
  output logic                                 is_zero,
  output logic                                 d_sign,
  output logic signed [ewidth-1:0]             d_exp,
  output logic        [$bits(in_data.mantissa):0] d_man
);

  localparam int man_width = $bits(in_data.mantissa);
  localparam int exp_width = $bits(in_data.exponent);
  localparam int exp_bias  = 2 ** (exp_width - 1) - 1;
  localparam int width     = man_width + 1;

  // ewidth is at least exp_width+2, so the zero-extended biased exponent is
  // always a non-negative signed value and E - bias cannot overflow.
  localparam logic signed [ewidth-1:0] bias_s    = ewidth'(exp_bias);
  localparam logic signed [ewidth-1:0] denorm_e  = ewidth'(1 - exp_bias);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic                      accept;
  logic                      inf_nxt;
  logic                      nan_nxt;
  logic                      zero_nxt;
  logic                      sign_nxt;
  logic signed [ewidth-1:0]  exp_nxt;
  logic        [width-1:0]   man_nxt;
  logic [exp_width-1:0]      in_e;
  logic [man_width-1:0]      in_m;

  assign in_e      = in_data.exponent;
  assign in_m      = in_data.mantissa;
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    inf_nxt   = is_inf;
    nan_nxt   = is_nan;
    zero_nxt  = is_zero;
    sign_nxt  = d_sign;
    exp_nxt   = d_exp;
    man_nxt   = d_man;

    // A new input can be taken from IDLE, or from DONE when the current
    // result leaves on this same edge; reset masks it off.
    in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    accept   = in_valid && in_ready;

    case (state)
      NORM: begin
        man_nxt = {d_man[width-2:0], 1'b0};
        exp_nxt = d_exp - ewidth'(1);
        // Leave on the shift that brings the leading one into the hidden bit.
        if (d_man[width-2]) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready && !in_valid) begin
          state_nxt = IDLE;
        end
      end
      default: begin
      end
    endcase

    if (accept) begin
      inf_nxt   = 1'b0;
      nan_nxt   = 1'b0;
      zero_nxt  = 1'b0;
      sign_nxt  = in_data.sign;
      state_nxt = DONE;
      if (in_e == '0) begin
        if (in_m == '0) begin
          zero_nxt = 1'b1;
          exp_nxt  = '0;
          man_nxt  = '0;
        end else begin
          exp_nxt   = denorm_e;
          man_nxt   = {1'b0, in_m};
          state_nxt = NORM;
        end
      end else if (in_e == '1) begin
        exp_nxt = '0;
        if (in_m == '0) begin
          inf_nxt = 1'b1;
          man_nxt = '0;
        end else begin
          // Payload kept verbatim so quiet/signalling bit survives.
          nan_nxt = 1'b1;
          man_nxt = {1'b0, in_m};
        end
      end else begin
        exp_nxt = $signed(ewidth'(in_e)) - bias_s;
        man_nxt = {1'b1, in_m};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      is_inf  <= 1'b0;
      is_nan  <= 1'b0;
      is_zero <= 1'b0;
      d_sign  <= 1'b0;
      d_exp   <= '0;
      d_man   <= '0;
    end else begin
      state   <= state_nxt;
      is_inf  <= inf_nxt;
      is_nan  <= nan_nxt;
      is_zero <= zero_nxt;
      d_sign  <= sign_nxt;
      d_exp   <= exp_nxt;
      d_man   <= man_nxt;
    end
  end

endmodule
